// File: rtl/ff_d_pkg.sv
// Shared limits for the ff_d register family.
`timescale 1ns/1ps
package ff_d_pkg;

    localparam int MIN_WIDTH  = 1;
    localparam int MIN_STAGES = 1;

    function automatic bit params_ok(input int width, input int stages);
        return (width >= MIN_WIDTH) && (stages >= MIN_STAGES);
    endfunction

endpackage

// File: rtl/ff_d_stage.sv
// Single WIDTH-bit flop, asynchronous active-high reset to RESET_VALUE.
`timescale 1ns/1ps
module ff_d_stage
    import ff_d_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            q <= RESET_VALUE;
        end else begin
            q <= din;
        end
    end

endmodule

// File: rtl/ff_d.sv
// D register / delay line: STAGES flops in series, latency STAGES cycles.
// rstn is active-high despite its name (1 = held in reset).
`timescale 1ns/1ps
module ff_d
    import ff_d_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] d
);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("ff_d: WIDTH and STAGES must both be >= 1");
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        if (i == 0) begin : g_head
            assign stage_d = in;
        end else begin : g_chain
            assign stage_d = stage_q[i-1];
        end

        ff_d_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk  (clk),
            .rstn (rstn),
            .din  (stage_d),
            .q    (stage_q[i])
        );
    end

    assign d = stage_q[STAGES-1];

endmodule

// File: tb/tb_ff_d.sv
// Directed bench for ff_d: 1-bit single stage and 8-bit three-stage delay line.
`timescale 1ns/1ps
module tb_ff_d;

    logic       clk;
    logic       rstn_a;
    logic       in_a;
    logic       d_a;
    logic       rstn_b;
    logic [7:0] in_b;
    logic [7:0] d_b;

    int checks = 0;
    int errors = 0;

    ff_d u_dut_a (
        .clk  (clk),
        .rstn (rstn_a),
        .in   (in_a),
        .d    (d_a)
    );

    ff_d #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (8'hA5)
    ) u_dut_b (
        .clk  (clk),
        .rstn (rstn_b),
        .in   (in_b),
        .d    (d_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        rstn_a = 1'b1;
        in_a   = 1'b0;
        rstn_b = 1'b1;
        in_b   = 8'h00;

        // Reset hold, input toggling, edge at t=5 ignored
        at(1);  chk("a_reset_t1", {7'd0, d_a}, 8'h00);
        at(3);  in_a = 1'b1;
        at(6);  chk("a_reset_after_edge5", {7'd0, d_a}, 8'h00);
        at(8);  in_a = 1'b0;
        at(9);  chk("b_reset_value", d_b, 8'hA5);

        // Release with undriven input
        at(11); rstn_a = 1'b0; in_a = 1'bx;
        at(14); chk("a_pre_edge15", {7'd0, d_a}, 8'h00);
        at(16); chk("a_x_propagates", {7'd0, d_a}, 8'b0000000x);

        // Capture 0 then 1, changes only at rising edges
        at(21); in_a = 1'b0;
        at(26); chk("a_capture0", {7'd0, d_a}, 8'h00);
        at(41); in_a = 1'b1;
        at(44); chk("a_hold0_before_edge45", {7'd0, d_a}, 8'h00);
        at(46); chk("a_capture1", {7'd0, d_a}, 8'h01);

        // Async reset between edges
        at(48); rstn_a = 1'b1;
        at(49); chk("a_async_clear", {7'd0, d_a}, 8'h00);
        at(52); rstn_a = 1'b0;
        at(54); chk("a_no_load_before_edge55", {7'd0, d_a}, 8'h00);
        at(56); chk("a_reload_after_release", {7'd0, d_a}, 8'h01);

        // Reset held across a rising edge with in=1
        at(57); rstn_a = 1'b1;
        at(58); chk("a_clear_again", {7'd0, d_a}, 8'h00);
        at(66); chk("a_edge_ignored_in_reset", {7'd0, d_a}, 8'h00);
        at(67); rstn_a = 1'b0;
        at(76); chk("a_load_after_release2", {7'd0, d_a}, 8'h01);
        at(86); chk("a_constant_reload", {7'd0, d_a}, 8'h01);

        // Three-stage delay line: 3C for one cycle, then 11
        at(91); rstn_b = 1'b0; in_b = 8'h3C;
        at(96); in_b = 8'h11;
                chk("b_edge1_still_reset", d_b, 8'hA5);
        at(106); chk("b_edge2_still_reset", d_b, 8'hA5);
        at(116); chk("b_edge3_pulse", d_b, 8'h3C);
        at(126); chk("b_edge4_next", d_b, 8'h11);

        // Async reset clears the whole chain
        at(128); rstn_b = 1'b1;
        at(129); chk("b_async_clear", d_b, 8'hA5);
        at(131); rstn_b = 1'b0;
        at(136); chk("b_flush_stage1", d_b, 8'hA5);
        at(156); chk("b_refill", d_b, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
